// File: rtl/rcl_pkg.sv
// ---------------------------------------------------------------------------
// rcl_pkg : shared types and widths for the RCL master and its golden model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rcl_pkg;

    localparam int COEF_W      = 5;
    localparam int PROD_W      = 12;
    localparam int CMP_W       = 24;
    localparam int WCNT_W      = 8;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BEAT0 = 3'd1,
        S_BEAT1 = 3'd2,
        S_BEAT2 = 3'd3,
        S_WAIT  = 3'd4,
        S_DONE  = 3'd5
    } state_e;

endpackage

`default_nettype wire

// File: rtl/rcl_golden.sv
// ---------------------------------------------------------------------------
// rcl_golden : combinational line/circle intersection count (0, 1 or 2)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rcl_golden
    import rcl_pkg::*;
(
    input  logic [COEF_W-1:0] a_i,
    input  logic [COEF_W-1:0] b_i,
    input  logic [COEF_W-1:0] c_i,
    input  logic [COEF_W-1:0] m_i,
    input  logic [COEF_W-1:0] n_i,
    input  logic [COEF_W-1:0] k_i,
    output logic [1:0]        cnt_o
);

    logic signed [PROD_W-1:0] a_s, b_s, c_s, m_s, n_s, s, sq_sum;
    logic signed [CMP_W-1:0]  s_w, rhs_s;
    logic [CMP_W-1:0]         lhs, rhs;

    // Compares squared distance-to-line against k*(a^2+b^2), all in integers
    always_comb begin
        a_s    = {{(PROD_W-COEF_W){a_i[COEF_W-1]}}, a_i};
        b_s    = {{(PROD_W-COEF_W){b_i[COEF_W-1]}}, b_i};
        c_s    = {{(PROD_W-COEF_W){c_i[COEF_W-1]}}, c_i};
        m_s    = {{(PROD_W-COEF_W){m_i[COEF_W-1]}}, m_i};
        n_s    = {{(PROD_W-COEF_W){n_i[COEF_W-1]}}, n_i};
        s      = a_s * m_s + b_s * n_s + c_s;
        sq_sum = a_s * a_s + b_s * b_s;
        s_w    = {{(CMP_W-PROD_W){s[PROD_W-1]}}, s};
        rhs_s  = s_w * s_w;
        rhs    = rhs_s;
        lhs    = {{(CMP_W-PROD_W){1'b0}}, sq_sum} * {{(CMP_W-COEF_W){1'b0}}, k_i};
        if (lhs > rhs)
            cnt_o = 2'd2;
        else if (lhs == rhs)
            cnt_o = 2'd1;
        else
            cnt_o = 2'd0;
    end

endmodule

`default_nettype wire

// File: rtl/rcl_master.sv
// ---------------------------------------------------------------------------
// rcl_master : sends one line/circle problem as three beats, checks the reply
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rcl_master
    import rcl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [COEF_W-1:0] req_a,
    input  logic [COEF_W-1:0] req_b,
    input  logic [COEF_W-1:0] req_c,
    input  logic [COEF_W-1:0] req_m,
    input  logic [COEF_W-1:0] req_n,
    input  logic [COEF_W-1:0] req_k,
    output logic              in_valid,
    output logic [COEF_W-1:0] coef_L,
    output logic [COEF_W-1:0] coef_Q,
    input  logic              out_valid,
    input  logic [1:0]        out,
    output logic              rsp_valid,
    output logic [1:0]        rsp_cnt,
    output logic [1:0]        rsp_exp,
    output logic              rsp_err,
    output logic              rsp_timeout
);

    state_e              state_q;
    logic [COEF_W-1:0]   a_q, b_q, c_q, m_q, n_q, k_q;
    logic [WCNT_W-1:0]   wcnt_q;
    logic                in_valid_q;
    logic [COEF_W-1:0]   coef_l_q, coef_q_q;
    logic                rsp_valid_q, rsp_err_q, rsp_timeout_q;
    logic [1:0]          rsp_cnt_q, rsp_exp_q;
    logic [1:0]          golden_cnt;

    rcl_golden u_golden (
        .a_i   (a_q),
        .b_i   (b_q),
        .c_i   (c_q),
        .m_i   (m_q),
        .n_i   (n_q),
        .k_i   (k_q),
        .cnt_o (golden_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            {a_q, b_q, c_q, m_q, n_q, k_q} <= '0;
            wcnt_q        <= '0;
            in_valid_q    <= 1'b0;
            coef_l_q      <= '0;
            coef_q_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_cnt_q     <= '0;
            rsp_exp_q     <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        a_q        <= req_a;
                        b_q        <= req_b;
                        c_q        <= req_c;
                        m_q        <= req_m;
                        n_q        <= req_n;
                        k_q        <= req_k;
                        in_valid_q <= 1'b1;
                        coef_l_q   <= req_a;
                        coef_q_q   <= req_m;
                        state_q    <= S_BEAT0;
                    end
                end
                S_BEAT0: begin
                    coef_l_q <= b_q;
                    coef_q_q <= n_q;
                    state_q  <= S_BEAT1;
                end
                S_BEAT1: begin
                    coef_l_q <= c_q;
                    coef_q_q <= k_q;
                    state_q  <= S_BEAT2;
                end
                S_BEAT2: begin
                    in_valid_q <= 1'b0;
                    coef_l_q   <= '0;
                    coef_q_q   <= '0;
                    wcnt_q     <= '0;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    // A reply arriving on the timeout cycle still counts as a reply
                    if (out_valid) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_cnt_q     <= out;
                        rsp_exp_q     <= golden_cnt;
                        rsp_err_q     <= (out != golden_cnt);
                        rsp_timeout_q <= 1'b0;
                        state_q       <= S_DONE;
                    end else if (wcnt_q == WCNT_W'(TIMEOUT - 1)) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_cnt_q     <= '0;
                        rsp_exp_q     <= golden_cnt;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        state_q       <= S_DONE;
                    end else begin
                        wcnt_q <= wcnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign in_valid    = in_valid_q;
    assign coef_L      = coef_l_q;
    assign coef_Q      = coef_q_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_cnt     = rsp_cnt_q;
    assign rsp_exp     = rsp_exp_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_rcl_master.sv
// ---------------------------------------------------------------------------
// tb_rcl_master : scoreboard bench for rcl_master with a behavioural responder
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rcl_master;

    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [4:0] req_a = '0, req_b = '0, req_c = '0, req_m = '0, req_n = '0, req_k = '0;
    logic       in_valid;
    logic [4:0] coef_L, coef_Q;
    logic       out_valid = 1'b0;
    logic [1:0] out_r = '0;
    logic       rsp_valid, rsp_err, rsp_timeout;
    logic [1:0] rsp_cnt, rsp_exp;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [1:0] cnt;
        logic [1:0] ex;
        logic       err;
        logic       to;
        int         rsp_j;
    } exp_t;

    exp_t       sb[$];
    logic [4:0] nxt [6];

    rcl_master #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_c       (req_c),
        .req_m       (req_m),
        .req_n       (req_n),
        .req_k       (req_k),
        .in_valid    (in_valid),
        .coef_L      (coef_L),
        .coef_Q      (coef_Q),
        .out_valid   (out_valid),
        .out         (out_r),
        .rsp_valid   (rsp_valid),
        .rsp_cnt     (rsp_cnt),
        .rsp_exp     (rsp_exp),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s got %0h want %0h", tag, act, req);
        end
    endtask

    function automatic logic [1:0] model(input logic [4:0] a, b, c, m, n, k);
        longint s, lhs, rhs;
        s   = longint'($signed(a)) * $signed(m) + longint'($signed(b)) * $signed(n) + $signed(c);
        rhs = s * s;
        lhs = (longint'($signed(a)) * $signed(a) + longint'($signed(b)) * $signed(b)) * longint'(k);
        if (lhs > rhs) return 2'd2;
        if (lhs == rhs) return 2'd1;
        return 2'd0;
    endfunction

    // rdly: WAIT cycle (1-based) in which the responder answers; 0 = silent
    task automatic do_txn(input logic [4:0] a, b, c, m, n, k, input int rdly,
                          input logic [1:0] rval, input bit hold, input bit immediate);
        int   w = 0;
        bit   seen = 0;
        exp_t e, p;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before_req", req_ready, 1);
        if (immediate) chk("b2b_accept_wait", w, 0);
        req_valid = 1'b1;
        req_a = a; req_b = b; req_c = c; req_m = m; req_n = n; req_k = k;
        e.ex = model(a, b, c, m, n, k);
        if (rdly >= 1 && rdly <= TO) begin
            e.cnt = rval; e.to = 1'b0; e.err = (rval != e.ex); e.rsp_j = 4 + rdly;
        end else begin
            e.cnt = 2'd0; e.to = 1'b1; e.err = 1'b1; e.rsp_j = 4 + TO;
        end
        sb.push_back(e);
        @(posedge clk);
        for (int j = 1; j <= 60 && !seen; j++) begin
            @(negedge clk);
            if (j == 1) begin
                if (hold) begin
                    req_a = nxt[0]; req_b = nxt[1]; req_c = nxt[2];
                    req_m = nxt[3]; req_n = nxt[4]; req_k = nxt[5];
                end else begin
                    req_valid = 1'b0;
                    req_a = 5'($urandom); req_b = 5'($urandom); req_c = 5'($urandom);
                    req_m = 5'($urandom); req_n = 5'($urandom); req_k = 5'($urandom);
                end
            end
            case (j)
                1: begin chk("beat0_v", in_valid, 1); chk("beat0_L", coef_L, a); chk("beat0_Q", coef_Q, m); end
                2: begin chk("beat1_v", in_valid, 1); chk("beat1_L", coef_L, b); chk("beat1_Q", coef_Q, n); end
                3: begin chk("beat2_v", in_valid, 1); chk("beat2_L", coef_L, c); chk("beat2_Q", coef_Q, k); end
                default: begin
                    chk("idle_in_valid", in_valid, 0);
                    chk("idle_coefs", {coef_L, coef_Q}, 0);
                end
            endcase
            if (rsp_valid) begin
                seen = 1;
                chk("rsp_latency", j, e.rsp_j);
                if (sb.size() > 0) begin
                    p = sb.pop_front();
                    chk("rsp_cnt", rsp_cnt, p.cnt);
                    chk("rsp_exp", rsp_exp, p.ex);
                    chk("rsp_err", rsp_err, p.err);
                    chk("rsp_timeout", rsp_timeout, p.to);
                end
            end
            // stray strobe at j==1 lands in BEAT0 and must be ignored
            out_valid = (j == 1) || (rdly > 0 && j == 3 + rdly);
            out_r     = (rdly > 0 && j == 3 + rdly) ? rval : 2'($urandom);
        end
        out_valid = 1'b0;
        chk("rsp_seen", seen, 1);
        @(negedge clk);
        chk("rsp_pulse_end", rsp_valid, 0);
        chk("rsp_hold_cnt", rsp_cnt, e.cnt);
        chk("rsp_hold_exp", rsp_exp, e.ex);
        chk("ready_after", req_ready, 1);
        chk("gap_in_valid", in_valid, 0);
    endtask

    task automatic rst_mid_beat1();
        bit bad = 0;
        req_valid = 1'b1;
        req_a = 5'd3; req_b = 5'd5; req_c = 5'd7; req_m = 5'd1; req_n = 5'd2; req_k = 5'd9;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_pre_beat1", coef_L, 5'd5);
        rst_n = 1'b0;
        #1;
        chk("rst_in_valid", in_valid, 0);
        chk("rst_coefs", {coef_L, coef_Q}, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_rsp", {rsp_valid, rsp_cnt, rsp_exp, rsp_err, rsp_timeout}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (rsp_valid || in_valid) bad = 1;
        end
        chk("rst_no_rsp", bad, 0);
        chk("rst_ready_after", req_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ready", req_ready, 1);
        chk("reset_in_valid", in_valid, 0);
        chk("reset_coefs", {coef_L, coef_Q}, 0);
        chk("reset_rsp", {rsp_valid, rsp_cnt, rsp_exp, rsp_err, rsp_timeout}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_txn(5'd1, 5'd0, 5'd0,  5'd0,  5'd0,  5'd4,  1, 2'd2, 0, 0);
        do_txn(5'd1, 5'd0, 5'h1E, 5'd0,  5'd0,  5'd4,  1, 2'd1, 0, 0);
        do_txn(5'd1, 5'd0, 5'h1E, 5'd0,  5'd0,  5'd4,  1, 2'd2, 0, 0);
        do_txn(5'd1, 5'd0, 5'h1D, 5'd0,  5'd0,  5'd4,  1, 2'd0, 0, 0);
        do_txn(5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'd31, 1, 2'd0, 0, 0);
        do_txn(5'd0, 5'd0, 5'd0,  5'd2,  5'd3,  5'd7,  2, 2'd1, 0, 0);
        do_txn(5'd0, 5'd0, 5'd3,  5'd2,  5'd3,  5'd7,  3, 2'd0, 0, 0);
        do_txn(5'd2, 5'd1, 5'd1,  5'd1,  5'd1,  5'd9,  0, 2'd0, 0, 0);
        do_txn(5'd1, 5'd0, 5'd0,  5'd0,  5'd0,  5'd4,  TO, 2'd2, 0, 0);

        nxt[0] = 5'd2; nxt[1] = 5'h1F; nxt[2] = 5'd1; nxt[3] = 5'd3; nxt[4] = 5'd4; nxt[5] = 5'd20;
        do_txn(5'd1, 5'd1, 5'd0, 5'd0, 5'd0, 5'd2, 1, 2'd2, 1, 0);
        do_txn(nxt[0], nxt[1], nxt[2], nxt[3], nxt[4], nxt[5], 2, 2'd0, 0, 1);

        rst_mid_beat1();
        do_txn(5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 1, 2'd2, 0, 0);

        for (int t = 0; t < 6; t++) begin
            do_txn(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                   5'($urandom), int'($urandom_range(1, 5)), 2'($urandom_range(0, 2)), 0, 0);
        end

        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rcl_master.md
RCL_MASTER -- requirements
Module: rcl_master

Interface
REQ-001 Parameter: TIMEOUT, 15, max cycles to wait for out_valid after the last beat (range 1..255).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  host offers one line/circle problem.
REQ-005 req_ready  output  1  high only in IDLE; accept occurs on a clock edge where req_valid && req_ready.
REQ-006 req_a, req_b, req_c, req_m, req_n  input  5 each  signed line (a,b,c) and circle centre (m,n) coefficients.
REQ-007 req_k  input  5  unsigned radius-squared term, 0..31.
REQ-008 in_valid  output  1  beat strobe toward the RCL responder.
REQ-009 coef_L  output  5  signed line coefficient beat.
REQ-010 coef_Q  output  5  signed circle coefficient beat.
REQ-011 out_valid  input  1  responder result strobe.
REQ-012 out  input  2  responder intersection count.
REQ-013 rsp_valid  output  1  one-cycle pulse: transaction finished.
REQ-014 rsp_cnt  output  2  captured out (0 on timeout).
REQ-015 rsp_exp  output  2  locally computed expected count.
REQ-016 rsp_err  output  1  rsp_cnt != rsp_exp, or timeout.
REQ-017 rsp_timeout  output  1  no out_valid within TIMEOUT cycles.

Function
REQ-018 FSM states: IDLE, BEAT0, BEAT1, BEAT2, WAIT, DONE; IDLE->BEAT0 on accept; BEAT0->BEAT1->BEAT2->WAIT unconditionally; WAIT->DONE on out_valid or timeout; DONE->IDLE unconditionally.
REQ-019 On accept, all six request fields are latched; later req_* changes have no effect on the transaction.
REQ-020 All responder-side outputs are registered: BEAT0 drives in_valid=1, coef_L=a, coef_Q=m; BEAT1 drives b,n; BEAT2 drives c,k (k as its 5-bit pattern).
REQ-021 The three beats are contiguous with no gaps; outside BEAT0..BEAT2, in_valid=0 and coef_L=coef_Q=0.
REQ-022 Latency: accept at edge T -> beats during cycles T+1..T+3; responder out_valid is nominally seen in cycle T+4; rsp_valid is high in cycle T+5.
REQ-023 WAIT has an 8-bit counter cleared on entry and incremented each WAIT cycle without out_valid; timeout fires when the counter reaches TIMEOUT.
REQ-024 If out_valid and timeout occur in the same cycle, out_valid wins: rsp_timeout=0 and out is captured.
REQ-025 out is captured only in WAIT with out_valid=1; out_valid in any other state is ignored.
REQ-026 Expected count: s = a*m + b*n + c (signed, 12 bit); rhs = s*s (unsigned, 24 bit); lhs = (a*a + b*b)*k (unsigned, 24 bit); rsp_exp = 2 if lhs>rhs, 1 if lhs==rhs, else 0.
REQ-027 The degenerate case a=b=0 uses the same formula without special handling (lhs=0).
REQ-028 rsp_cnt, rsp_exp, rsp_err and rsp_timeout are valid while rsp_valid=1 and hold their values until the next DONE.
REQ-029 No new request is accepted in BEAT0..DONE; a pending req_valid is accepted in the first IDLE cycle.

Reset
REQ-030 rst_n low immediately forces IDLE and clears the WAIT counter and latched fields.
REQ-031 rst_n low immediately drives in_valid, coef_L, coef_Q, rsp_valid, rsp_cnt, rsp_exp, rsp_err and rsp_timeout to 0, and drives req_ready to 1.
REQ-032 Reset asserted mid-transaction (any beat or WAIT) abandons that transaction with no rsp_valid pulse; operation resumes from IDLE.

Structure
REQ-033 Shared package rcl_pkg holds the state enum, coefficient width (5), product/compare widths (12/24) and the TIMEOUT default.
REQ-034 One sub-module, rcl_golden, is purely combinational: latched a,b,c,m,n,k in, expected count (2 bit) out; it is reusable by the bench scoreboard.

Verification
REQ-035 a=1,b=0,c=0,m=0,n=0,k=4, responder returns 2 -> beats (1,0),(0,0),(0,4); rsp_exp=2, rsp_cnt=2, rsp_err=0, rsp_valid at T+5.
REQ-036 a=1,b=0,c=-2,m=0,n=0,k=4 (tangent), responder returns 1 -> rsp_exp=1, rsp_err=0; same request with responder returning 2 -> rsp_err=1.
REQ-037 a=1,b=0,c=-3,m=0,n=0,k=4 -> rsp_exp=0; a=-16,b=-16,c=-16,m=-16,n=-16,k=31 -> lhs=15872, rhs=246016, rsp_exp=0 (no overflow).
REQ-038 Responder silent, TIMEOUT=15 -> rsp_valid 15 cycles after WAIT entry with rsp_timeout=1, rsp_cnt=0, rsp_err=1; out_valid exactly on the timeout cycle -> rsp_timeout=0 and out captured.
REQ-039 req_valid held high for two back-to-back requests -> second accepted in the IDLE cycle after DONE, and in_valid=0 between the two beat bursts.
REQ-040 rst_n pulsed low during BEAT1 -> in_valid=0 immediately, no rsp_valid pulse, and req_ready=1 after release.
